// File: rtl/gamma_lut_pipe.sv
// gamma_lut_pipe: per-channel double-banked gamma LUT, two-stage stall-all pipe, bank swap at frame end.
// Define GAMMA_READBACK_EN to add host readback of the shadow bank (tbl_re / tbl_rdata).
module gamma_lut_pipe #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 8,
  parameter int CHANNELS  = 3,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [CHANNELS*IN_WIDTH-1:0]  s_data,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CHANNELS*OUT_WIDTH-1:0] m_data,
  output logic                          m_last,
  input  logic                          tbl_we,
  input  logic [CW-1:0]                 tbl_chan,
  input  logic [IN_WIDTH-1:0]           tbl_addr,
  input  logic [OUT_WIDTH-1:0]          tbl_wdata,
  input  logic                          tbl_swap,
  output logic                          swap_pending,
  output logic                          active_bank
`ifdef GAMMA_READBACK_EN
  ,
  input  logic                          tbl_re,
  output logic [OUT_WIDTH-1:0]          tbl_rdata
`endif
);

  localparam int DEPTH = 2 ** IN_WIDTH;

  typedef enum logic {IDLE, PENDING} swap_state_e;

  swap_state_e state_q, state_d;
  logic        bank_q, bank_d;

  logic [OUT_WIDTH-1:0] mem_q [CHANNELS][2][DEPTH];

  logic adv, accept, chan_ok;
  logic v1_q, last1_q;
  logic [CHANNELS*OUT_WIDTH-1:0] rd_q;
  logic m_valid_q, m_last_q;
  logic [CHANNELS*OUT_WIDTH-1:0] m_data_q;

  assign adv     = !m_valid_q || m_ready;
  assign s_ready = adv;
  assign accept  = s_valid && adv;
  assign chan_ok = 32'(tbl_chan) < 32'(CHANNELS);

  // Host writes only ever land in the shadow bank, so lookups never see a half-written curve.
  always_ff @(posedge clk) begin
    if (tbl_we && chan_ok) begin
      mem_q[tbl_chan][!bank_q][tbl_addr] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      for (int c = 0; c < CHANNELS; c++) begin
        rd_q[c*OUT_WIDTH +: OUT_WIDTH] <= mem_q[c][bank_q][s_data[c*IN_WIDTH +: IN_WIDTH]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else if (adv) begin
      v1_q      <= s_valid;
      last1_q   <= s_valid && s_last;
      m_valid_q <= v1_q;
      m_last_q  <= last1_q;
      m_data_q  <= rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
    end
  end

  // A swap request only commits once the current frame's last beat has been accepted.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    case (state_q)
      IDLE: begin
        if (tbl_swap) state_d = PENDING;
      end
      PENDING: begin
        if (accept && s_last) begin
          state_d = IDLE;
          bank_d  = !bank_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_valid      = m_valid_q;
  assign m_last       = m_last_q;
  assign m_data       = m_data_q;
  assign swap_pending = (state_q == PENDING);
  assign active_bank  = bank_q;

`ifdef GAMMA_READBACK_EN
  logic [OUT_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (tbl_re) begin
      rdata_q <= chan_ok ? mem_q[tbl_chan][!bank_q][tbl_addr] : '0;
    end
  end

  assign tbl_rdata = rdata_q;
`endif

endmodule
